// File: rtl/ucie_ctl_sb_tx_sched.sv
// RDI sideband transmit scheduler: round-robin arbitration, credit gating, NC-bit beat serialization.
// Optional build macro UCIE_SB_TX_PRIO_EN gives requester 0 strict priority.
module ucie_ctl_sb_tx_sched #(
    parameter  int NC      = 32,
    parameter  int N_REQ   = 3,
    parameter  int CREDITS = 4,
    localparam int BEATS   = 64 / NC,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ-1:0]      i_has_data,
    input  logic [N_REQ*64-1:0]   i_hdr,
    input  logic [N_REQ*64-1:0]   i_data,
    input  logic                  i_rdi_pl_cfg_crd,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [N_REQ-1:0]      o_done,
    output logic                  o_rdi_lp_cfg_vld,
    output logic [NC-1:0]         o_rdi_lp_cfg,
    output logic                  o_busy,
    output logic [CW-1:0]         o_credits,
    output logic                  o_crd_err
);

    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNTW = (2 * BEATS > 1) ? $clog2(2 * BEATS) : 1;
    localparam logic [CNTW-1:0] LAST_HDR  = CNTW'(BEATS - 1);
    localparam logic [CNTW-1:0] LAST_DATA = CNTW'(2 * BEATS - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t             state_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [127:0]       msg_q;
    logic               has_data_q;
    logic [N_REQ-1:0]   win_q;
    logic [CNTW-1:0]    cnt_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   done_q;
    logic               vld_q;
    logic [NC-1:0]      cfg_q;
    logic [CW-1:0]      credits_q;
    logic [CW-1:0]      credits_d;
    logic               crd_err_q;
    logic               crd_err_d;

    logic               found_s;
    logic               prio_hit_s;
    logic [PW-1:0]      win_idx_s;
    logic [N_REQ-1:0]   win_oh_s;
    logic               gnt_fire_s;
    logic [63:0]        hdr_sel_s;
    logic [63:0]        data_sel_s;
    logic               sel_has_data_s;
    logic               first_is_last_s;
    logic [CNTW-1:0]    last_s;

    // Round-robin search starting after the last winner; requester 0 can preempt when priority is built in.
    always_comb begin : arb_p
        int            cand;
        logic [PW-1:0] cand_idx;
        logic          take;
        found_s    = 1'b0;
        win_idx_s  = '0;
        prio_hit_s = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        take       = 1'b0;
`ifdef UCIE_SB_TX_PRIO_EN
        prio_hit_s = i_req[0];
`endif
        for (int i = 1; i <= N_REQ; i++) begin
            cand      = int'(rr_ptr_q) + i;
            cand      = (cand >= N_REQ) ? (cand - N_REQ) : cand;
            cand_idx  = PW'(cand);
            take      = !found_s && i_req[cand_idx];
            win_idx_s = take ? cand_idx : win_idx_s;
            found_s   = found_s | take;
        end
        win_idx_s = prio_hit_s ? '0 : win_idx_s;
        found_s   = found_s | prio_hit_s;
    end

    // Winner decode and payload selection.
    always_comb begin
        gnt_fire_s      = (state_q == ST_IDLE) && found_s && (credits_q != '0);
        win_oh_s        = N_REQ'(1'b1) << win_idx_s;
        hdr_sel_s       = i_hdr[64 * win_idx_s +: 64];
        data_sel_s      = i_data[64 * win_idx_s +: 64];
        sel_has_data_s  = i_has_data[win_idx_s];
        first_is_last_s = !sel_has_data_s && (BEATS == 1);
        last_s          = has_data_q ? LAST_DATA : LAST_HDR;
    end

    // Credit accounting: a grant and a return in the same cycle cancel out.
    always_comb begin
        credits_d = credits_q;
        crd_err_d = crd_err_q;
        case ({gnt_fire_s, i_rdi_pl_cfg_crd})
            2'b10: credits_d = credits_q - CW'(1);
            2'b01: begin
                if (credits_q == CW'(CREDITS)) begin
                    crd_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CW'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    // Credit counter and sticky overflow flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            credits_q <= CW'(CREDITS);
            crd_err_q <= 1'b0;
        end else begin
            credits_q <= credits_d;
            crd_err_q <= crd_err_d;
        end
    end

    // Message FSM; the state register tracks the cycles in which a beat is on the pins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= PW'(N_REQ - 1);
            msg_q      <= '0;
            has_data_q <= 1'b0;
            win_q      <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            vld_q      <= 1'b0;
            cfg_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_fire_s) begin
                        state_q    <= ST_SEND;
                        rr_ptr_q   <= prio_hit_s ? rr_ptr_q : win_idx_s;
                        msg_q      <= {data_sel_s, hdr_sel_s} >> NC;
                        has_data_q <= sel_has_data_s;
                        win_q      <= win_oh_s;
                        cnt_q      <= '0;
                        gnt_q      <= win_oh_s;
                        done_q     <= first_is_last_s ? win_oh_s : '0;
                        vld_q      <= 1'b1;
                        cfg_q      <= hdr_sel_s[NC-1:0];
                    end else begin
                        gnt_q  <= '0;
                        done_q <= '0;
                        vld_q  <= 1'b0;
                        cfg_q  <= '0;
                    end
                end
                ST_SEND: begin
                    gnt_q <= '0;
                    if (cnt_q == last_s) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        done_q  <= '0;
                        vld_q   <= 1'b0;
                        cfg_q   <= '0;
                    end else begin
                        cnt_q  <= cnt_q + CNTW'(1);
                        msg_q  <= msg_q >> NC;
                        cfg_q  <= msg_q[NC-1:0];
                        done_q <= ((cnt_q + CNTW'(1)) == last_s) ? win_q : '0;
                        vld_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    vld_q   <= 1'b0;
                    cfg_q   <= '0;
                end
            endcase
        end
    end

    assign o_gnt            = gnt_q;
    assign o_done           = done_q;
    assign o_rdi_lp_cfg_vld = vld_q;
    assign o_rdi_lp_cfg     = cfg_q;
    assign o_busy           = (state_q == ST_SEND);
    assign o_credits        = credits_q;
    assign o_crd_err        = crd_err_q;

endmodule

// File: tb/tb_ucie_ctl_sb_tx_sched.sv
// Directed bench for ucie_ctl_sb_tx_sched (NC=32, N_REQ=3, CREDITS=4).
module tb_ucie_ctl_sb_tx_sched;

    logic          i_clk;
    logic          i_rst;
    logic [2:0]    i_req;
    logic [2:0]    i_has_data;
    logic [191:0]  i_hdr;
    logic [191:0]  i_data;
    logic          i_rdi_pl_cfg_crd;
    logic [2:0]    o_gnt;
    logic [2:0]    o_done;
    logic          o_rdi_lp_cfg_vld;
    logic [31:0]   o_rdi_lp_cfg;
    logic          o_busy;
    logic [2:0]    o_credits;
    logic          o_crd_err;

    int errors = 0;
    int checks = 0;
    int exp_rr[6];
    int exp_ex[5];

    ucie_ctl_sb_tx_sched #(.NC(32), .N_REQ(3), .CREDITS(4)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req            (i_req),
        .i_has_data       (i_has_data),
        .i_hdr            (i_hdr),
        .i_data           (i_data),
        .i_rdi_pl_cfg_crd (i_rdi_pl_cfg_crd),
        .o_gnt            (o_gnt),
        .o_done           (o_done),
        .o_rdi_lp_cfg_vld (o_rdi_lp_cfg_vld),
        .o_rdi_lp_cfg     (o_rdi_lp_cfg),
        .o_busy           (o_busy),
        .o_credits        (o_credits),
        .o_crd_err        (o_crd_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] e;
`ifdef UCIE_SB_TX_PRIO_EN
        exp_rr = '{0, 0, 0, 0, 0, 0};
        exp_ex = '{0, 0, 0, 0, 0};
`else
        exp_rr = '{0, 1, 2, 0, 1, 2};
        exp_ex = '{0, 1, 2, 0, 1};
`endif
        i_rst = 1'b1;
        i_req = 3'b000;
        i_has_data = 3'b000;
        i_hdr = 192'd0;
        i_data = 192'd0;
        i_rdi_pl_cfg_crd = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 64'(o_gnt), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_vld", 64'(o_rdi_lp_cfg_vld), 64'd0);
        chk("rst_cfg", 64'(o_rdi_lp_cfg), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_credits", 64'(o_credits), 64'd4);
        chk("rst_crd_err", 64'(o_crd_err), 64'd0);
        i_rst = 1'b0;
        tick();

        // Header-only message from requester 0
        i_req = 3'b001;
        i_hdr[63:0] = 64'h1122334455667788;
        tick();
        chk("h_gnt", 64'(o_gnt), 64'h1);
        chk("h_beat0", 64'(o_rdi_lp_cfg), 64'h55667788);
        chk("h_vld0", 64'(o_rdi_lp_cfg_vld), 64'd1);
        chk("h_done0", 64'(o_done), 64'd0);
        chk("h_busy", 64'(o_busy), 64'd1);
        chk("h_credits", 64'(o_credits), 64'd3);
        i_req = 3'b000;
        i_hdr[63:0] = 64'hDEADDEADDEADDEAD;
        tick();
        chk("h_beat1", 64'(o_rdi_lp_cfg), 64'h11223344);
        chk("h_done1", 64'(o_done), 64'h1);
        chk("h_gnt1", 64'(o_gnt), 64'd0);
        tick();
        chk("h_idle_vld", 64'(o_rdi_lp_cfg_vld), 64'd0);
        chk("h_idle_cfg", 64'(o_rdi_lp_cfg), 64'd0);
        chk("h_idle_busy", 64'(o_busy), 64'd0);

        // Header plus data from requester 2
        i_req = 3'b100;
        i_has_data = 3'b100;
        i_hdr[191:128] = 64'h0102030405060708;
        i_data[191:128] = 64'hAAAABBBBCCCCDDDD;
        tick();
        chk("d_gnt", 64'(o_gnt), 64'h4);
        chk("d_beat0", 64'(o_rdi_lp_cfg), 64'h05060708);
        chk("d_credits", 64'(o_credits), 64'd2);
        i_req = 3'b000;
        i_has_data = 3'b000;
        tick();
        chk("d_beat1", 64'(o_rdi_lp_cfg), 64'h01020304);
        chk("d_done1", 64'(o_done), 64'd0);
        tick();
        chk("d_beat2", 64'(o_rdi_lp_cfg), 64'hCCCCDDDD);
        chk("d_done2", 64'(o_done), 64'd0);
        tick();
        chk("d_beat3", 64'(o_rdi_lp_cfg), 64'hAAAABBBB);
        chk("d_done3", 64'(o_done), 64'h4);
        tick();
        chk("d_idle_vld", 64'(o_rdi_lp_cfg_vld), 64'd0);

        // Credit returns up to the limit, then one too many
        i_rdi_pl_cfg_crd = 1'b1;
        tick();
        chk("crd_3", 64'(o_credits), 64'd3);
        tick();
        chk("crd_4", 64'(o_credits), 64'd4);
        chk("crd_err_clear", 64'(o_crd_err), 64'd0);
        tick();
        chk("crd_sat", 64'(o_credits), 64'd4);
        chk("crd_err_set", 64'(o_crd_err), 64'd1);
        i_rdi_pl_cfg_crd = 1'b0;
        tick();
        chk("crd_err_sticky", 64'(o_crd_err), 64'd1);

        // Round-robin with a credit return on every grant cycle
        for (int k = 0; k < 3; k++) begin
            i_hdr[64*k +: 64] = {16'h5A5A, 16'(k), 16'hC0DE, 16'(k)};
        end
        i_req = 3'b111;
        for (int m = 0; m < 6; m++) begin
            i_rdi_pl_cfg_crd = 1'b1;
            tick();
            e = 3'b001 << exp_rr[m];
            chk($sformatf("rr_gnt%0d", m), 64'(o_gnt), 64'(e));
            chk($sformatf("rr_beat%0d", m), 64'(o_rdi_lp_cfg), 64'({16'hC0DE, 16'(exp_rr[m])}));
            chk($sformatf("rr_cred%0d", m), 64'(o_credits), 64'd4);
            i_rdi_pl_cfg_crd = 1'b0;
            tick();
            chk($sformatf("rr_done%0d", m), 64'(o_done), 64'(e));
            tick();
            chk($sformatf("rr_idle%0d", m), 64'(o_rdi_lp_cfg_vld), 64'd0);
        end
        chk("rr_crd_err", 64'(o_crd_err), 64'd1);

        // Credit exhaustion: four grants, then stall until a return
        for (int m = 0; m < 4; m++) begin
            tick();
            e = 3'b001 << exp_ex[m];
            chk($sformatf("ex_gnt%0d", m), 64'(o_gnt), 64'(e));
            chk($sformatf("ex_cred%0d", m), 64'(o_credits), 64'(3 - m));
            tick();
            tick();
        end
        for (int m = 0; m < 3; m++) begin
            tick();
            chk($sformatf("ex_stall_gnt%0d", m), 64'(o_gnt), 64'd0);
            chk($sformatf("ex_stall_vld%0d", m), 64'(o_rdi_lp_cfg_vld), 64'd0);
        end
        chk("ex_zero", 64'(o_credits), 64'd0);
        i_rdi_pl_cfg_crd = 1'b1;
        tick();
        chk("ex_one", 64'(o_credits), 64'd1);
        chk("ex_nogrant", 64'(o_gnt), 64'd0);
        i_rdi_pl_cfg_crd = 1'b0;
        tick();
        e = 3'b001 << exp_ex[4];
        chk("ex_regrant", 64'(o_gnt), 64'(e));
        chk("ex_zero_again", 64'(o_credits), 64'd0);
        i_req = 3'b000;
        tick();
        tick();

        // Reset in the middle of a four-beat message
        i_rdi_pl_cfg_crd = 1'b1;
        tick();
        i_rdi_pl_cfg_crd = 1'b0;
        i_req = 3'b010;
        i_has_data = 3'b010;
        i_data[127:64] = 64'h0F0F0F0FF0F0F0F0;
        tick();
        chk("rm_gnt", 64'(o_gnt), 64'h2);
        i_req = 3'b000;
        i_has_data = 3'b000;
        tick();
        chk("rm_beat2_vld", 64'(o_rdi_lp_cfg_vld), 64'd1);
        i_rst = 1'b1;
        #1;
        chk("rm_vld", 64'(o_rdi_lp_cfg_vld), 64'd0);
        chk("rm_credits", 64'(o_credits), 64'd4);
        chk("rm_busy", 64'(o_busy), 64'd0);
        chk("rm_done", 64'(o_done), 64'd0);
        chk("rm_crd_err", 64'(o_crd_err), 64'd0);
        tick();
        i_rst = 1'b0;
        for (int m = 0; m < 3; m++) begin
            tick();
            chk($sformatf("rm_after_done%0d", m), 64'(o_done), 64'd0);
            chk($sformatf("rm_after_vld%0d", m), 64'(o_rdi_lp_cfg_vld), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ucie_ctl_sb_tx_sched.md
Name: ucie_ctl_sb_tx_sched

Overview:
- Transmit-side scheduler for the RDI sideband config channel (o_rdi_lp_cfg / o_rdi_lp_cfg_vld).
- Arbitrates among N_REQ message sources (CNTL link-management messages, advertised-capability messages, error messages) and serializes each 64-bit header and optional 64-bit data payload into NC-bit beats.
- Gates every message on the remote credit count returned via i_rdi_pl_cfg_crd.
- Sits between the controller/sideband message encoders and the RDI pins.

Parameters:
- NC, 32, sideband beat width in bits; legal values 16, 32, 64; BEATS = 64/NC.
- N_REQ, 3, number of requesters.
- CREDITS, 4, initial and maximum credit count; counter width CW = $clog2(CREDITS+1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_req  in  N_REQ  per-requester message request, level.
- i_has_data  in  N_REQ  message carries a 64-bit data payload.
- i_hdr  in  N_REQ*64  packed headers; requester k uses bits [64k+63:64k].
- i_data  in  N_REQ*64  packed data payloads, same packing as i_hdr.
- i_rdi_pl_cfg_crd  in  1  credit return, one credit per cycle high.
- o_gnt  out  N_REQ  one-hot pulse; message latched.
- o_done  out  N_REQ  one-hot pulse on the last beat of a message.
- o_rdi_lp_cfg_vld  out  1  beat valid.
- o_rdi_lp_cfg  out  NC  beat data.
- o_busy  out  1  high while in SEND.
- o_credits  out  CW  current credit count.
- o_crd_err  out  1  sticky; credit return received while at CREDITS.

Behaviour:
- Reset values: o_gnt=0, o_done=0, o_rdi_lp_cfg_vld=0, o_rdi_lp_cfg=0, o_busy=0, o_credits=CREDITS, o_crd_err=0, state=IDLE, rr_ptr=N_REQ-1. Reset is asynchronous: asserting it mid-message drops vld immediately, discards the message, and sends no o_done.
- FSM states: IDLE, SEND.
- IDLE:
  - If (i_req != 0) and credits > 0, pick a winner by round-robin, searching from rr_ptr+1 with wrap-around.
  - Assert o_gnt[w] for 1 cycle (registered; visible the cycle after the decision).
  - Latch hdr, data, and has_data for the winner; rr_ptr <= w; credits decrement; go to SEND.
  - If credits == 0, no grant; requests wait.
- SEND:
  - One beat per cycle, vld=1 on every beat, no stalls.
  - Beat order: header LSB-first (bits [NC-1:0] first), then data LSB-first if has_data.
  - Total beats: BEATS, or 2*BEATS when has_data.
  - The beat counter counts 0 to total-1.
  - On the last beat, assert o_done[w] in the same cycle; next state is IDLE, with vld=0 and o_rdi_lp_cfg=0 there.
- Timing:
  - Request seen in IDLE at cycle t: o_gnt at t+1, first beat at t+1.
  - There is a minimum 1 idle cycle between messages.
  - Example: NC=32, header-only message = 2 beats.
- Requester rules:
  - A requester holds i_req and its payload stable until o_gnt.
  - Deasserting i_req before grant withdraws the request with no side effects.
  - Payload may change after o_gnt.
  - i_req held after o_done is treated as a new message.
- Credits:
  - crd pulse alone: +1.
  - Grant alone: -1.
  - Both in the same cycle: unchanged.
  - crd pulse with credits == CREDITS and no grant: count saturates and o_crd_err is set (cleared only by reset).
  - Credits are never negative; no grant is issued at 0.
- o_busy = (state == SEND).

Optional Feature:
- Macro UCIE_SB_TX_PRIO_EN.
- When defined: requester 0 (link-management messages) has strict priority. It wins whenever i_req[0]=1; the round-robin among the remaining requesters applies only when i_req[0]=0, and rr_ptr is not updated on a requester-0 grant.
- When undefined: pure round-robin across all N_REQ requesters.

Test Plan:
- Header-only message (NC=32):
  - Stimulus: i_req=3'b001, hdr0=64'h1122334455667788, has_data=0.
  - Response: o_gnt=001; beats 32'h55667788 then 32'h11223344; o_done[0] on the 2nd beat; credits 4→3.
- Message with data:
  - Stimulus: requester 2, has_data=1, data=64'hAAAABBBBCCCCDDDD.
  - Response: 4 beats, last two are 32'hCCCCDDDD then 32'hAAAABBBB; o_done[2] on the 4th beat.
- Round-robin:
  - Stimulus: i_req=3'b111 held through 6 messages.
  - Response: grant order 0,1,2,0,1,2; one idle cycle between messages.
- Credit exhaustion:
  - Stimulus: 4 messages with no crd return; 5th request held; then a crd pulse.
  - Response: no 5th grant while credits=0; grant the cycle after credits reach 1.
- Simultaneous and overflow credit events:
  - Grant plus crd pulse in the same cycle: count unchanged.
  - crd pulse with credits=4: count stays 4, o_crd_err=1 and stays high until i_rst.
- Reset mid-message and priority macro:
  - i_rst during beat 2 of 4: vld=0 at once, credits=4, no o_done.
  - With UCIE_SB_TX_PRIO_EN and i_req=3'b111 held: requester 0 wins every arbitration.
